chunk_serial_adder: RTL
=======================

Name: chunk_serial_adder

Overview:
- Multi-cycle, parametrised add/subtract unit. Successor to the combinational n-bit ripple adder.
- Processes a WIDTH-bit operand pair CHUNK bits per clock through a small ripple slice, carrying between chunks in a register.
- Trades latency for a short carry chain.
- Used wherever wide add/sub is needed at clock rates the full ripple chain cannot meet. Driven by a start/done handshake.

Parameters:
- WIDTH, 16, operand and result width in bits (>=2).
- CHUNK, 4, bits processed per cycle (1..WIDTH).
- N (derived, localparam), ceil(WIDTH/CHUNK), number of processing cycles.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- sub  input  1  0: a+b+cin; 1: a-b-cin (cin acts as borrow-in).
- a  input  WIDTH  operand A, captured on accept.
- b  input  WIDTH  operand B, captured on accept.
- cin  input  1  carry-in (borrow-in when sub=1), captured on accept.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; results valid and stable from this cycle.
- s  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1. In sub mode, 1 = no borrow.
- ovf  output  1  signed (two's complement) overflow.

Behaviour:
- States: IDLE, RUN, DONE. Reset forces IDLE and clears all of the following to 0: busy, done, s, cout, ovf, the chunk index, the carry register and the operand registers.
- Accept:
  - start=1 at a rising edge while busy=0 (state IDLE or DONE) moves the block to RUN.
  - On accept, capture A=a and B'=(sub ? ~b : b).
  - Initial carry = (sub ? ~cin : cin).
  - Chunk index k = 0.
  - Back-to-back accept from DONE is allowed, giving zero bubble.
- RUN:
  - Each edge adds chunk k: bits [k*CHUNK +: CHUNK], clipped at WIDTH-1.
  - A[chunk] + B'[chunk] + carry writes the sum bits into an internal result register and updates carry; then k = k+1.
  - A partial last chunk (WIDTH mod CHUNK != 0) processes only the remaining bits. Its carry-out is taken from bit WIDTH-1, not from the chunk MSB.
  - During the last chunk, record the carry into bit WIDTH-1. On completion, ovf = carry_into_msb XOR carry_out_of_msb.
- Completion:
  - The edge processing chunk N-1 moves the block to DONE and loads s, cout and ovf.
  - done=1 for exactly that one cycle; busy=0.
  - Next edge: IDLE, unless a new start is accepted.
- Timing:
  - start sampled at edge E0.
  - busy=1 after E0 through the cycle before EN.
  - done=1 after EN for one cycle.
  - Latency is N cycles from accept to done.
- Output holding:
  - s, cout and ovf change only when done rises. They hold their values through later RUN periods until the next completion.
- Ignored inputs:
  - start while busy=1 is ignored; no queuing.
  - a, b, cin and sub changing during RUN have no effect.
- Reset mid-operation: immediate abort. Outputs return to 0 and no done pulse is produced.
- CHUNK=WIDTH degenerates to N=1: done one cycle after accept.

Test Plan:
- WIDTH=7, CHUNK=3 (N=3), add: a=1011011, b=0101011, cin=0, sub=0, start pulse -> done exactly 3 cycles after accept with s=0000110, cout=1, ovf=0. busy high for the 3 cycles before done.
- WIDTH=7, CHUNK=3, subtract:
  - a=0000101, b=0000011, cin=0, sub=1 -> s=0000010, cout=1, ovf=0.
  - Then a=0000011, b=0000101 -> s=1111110, cout=0, ovf=0.
- Overflow, WIDTH=7: a=0111111, b=0000001, add -> s=1000000, cout=0, ovf=1. Then a=1000000, b=0000001, sub=1 -> s=0111111, cout=1, ovf=1.
- Busy and back-to-back, WIDTH=16, CHUNK=4:
  - Issue 0x00FF+0x0001 (cin=1). While busy, pulse start with a=0xFFFF and hold a changing -> result 0x0101, cout=0; the second start is ignored.
  - start asserted in the done cycle with 0xFFFF+0x0001 -> accepted, next done after 4 cycles with s=0x0000, cout=1, ovf=0.
- Reset mid-op: accept 0x1234+0x1111, then drop rst_n asynchronously after 2 cycles -> busy, done, s, cout and ovf are 0 immediately. No done pulse follows. A fresh start after release gives 0x2345 in 4 cycles.
- Degenerate CHUNK=WIDTH=8: 0x7F+0x01 -> done 1 cycle after accept, s=0x80, cout=0, ovf=1.

Source files
------------

// File: rtl/chunk_serial_adder.sv
// Chunk-serial add/subtract: WIDTH-bit operands are summed CHUNK bits per clock,
// with the inter-chunk carry held in a register; start/done handshake.
module chunk_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, s_q, s_d;
    logic             cout_q, cout_d, ovf_q, ovf_d;

    logic             accept, last;
    logic [WIDTH-1:0] chunk_sum;
    logic             chunk_cout, chunk_cmsb;

    assign accept = start && (state_q != RUN);
    assign last   = (k_q == KW'(N - 1));

    // Ripple slice over chunk k; bits past WIDTH-1 are skipped so the final
    // carry is the true carry out of the MSB even for a partial last chunk.
    always_comb begin
        int   p;
        logic c;
        p          = 0;
        c          = carry_q;
        chunk_sum  = res_q;
        chunk_cmsb = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            p = int'(k_q) * CHUNK + i;
            if (p < WIDTH) begin
                if (p == WIDTH - 1) chunk_cmsb = c;
                chunk_sum[p] = a_q[p] ^ b_q[p] ^ c;
                c = (a_q[p] & b_q[p]) | (c & (a_q[p] ^ b_q[p]));
            end
        end
        chunk_cout = c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        s    = s_q;
        cout = cout_q;
        ovf  = ovf_q;
    end

    // Subtraction is a + ~b + ~borrow, so inversion happens once at capture.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        k_d     = k_q;
        res_d   = res_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (accept) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub ? ~cin : cin;
            k_d     = '0;
        end else if (state_q == RUN) begin
            res_d   = chunk_sum;
            carry_d = chunk_cout;
            k_d     = k_q + KW'(1);
            if (last) begin
                s_d    = chunk_sum;
                cout_d = chunk_cout;
                ovf_d  = chunk_cmsb ^ chunk_cout;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            res_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            res_q   <= res_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule
